instr_encoder: RTL and testbench

//   Encodes a stream of symbolic MIPS instruction requests into 32-bit machine words.
//   It is the producing end of the word format that the control decoder consumes.

---
 rtl/instr_encoder_pkg.sv | 68 ++++++
 rtl/instr_encoder_fmt.sv | 62 ++++++
 rtl/instr_encoder.sv | 127 ++++++++++++
 tb/tb_instr_encoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: mnemonic request codes,
// machine opcode/funct values, FSM states and word-packing helpers.
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    ENC_ADD     = 5'd0,
    ENC_SUB     = 5'd1,
    ENC_AND     = 5'd2,
    ENC_OR      = 5'd3,
    ENC_SLT     = 5'd4,
    ENC_JR      = 5'd5,
    ENC_SYSCALL = 5'd6,
    ENC_ADDI    = 5'd7,
    ENC_ADDIU   = 5'd8,
    ENC_SLTIU   = 5'd9,
    ENC_ORI     = 5'd10,
    ENC_LUI     = 5'd11,
    ENC_LW      = 5'd12,
    ENC_SW      = 5'd13,
    ENC_BEQ     = 5'd14,
    ENC_BNE     = 5'd15,
    ENC_J       = 5'd16,
    ENC_JAL     = 5'd17,
    ENC_LI      = 5'd18,
    ENC_NOP     = 5'd19
  } enc_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LI2  = 1'b1
  } state_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opcode, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opcode, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] opcode, input logic [25:0] target);
    return {opcode, target};
  endfunction

endpackage

// File: rtl/instr_encoder_fmt.sv
// Combinational formatter: one symbolic request (or the second LI half) to a
// machine word, plus flags for a pending second word and an unsupported op.
module instr_encoder_fmt
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  input  logic        li_phase,
  output logic [31:0] word,
  output logic        needs_second,
  output logic        err
);

  logic [15:0] imm_hi;
  logic [15:0] imm_lo;

  assign imm_hi = imm[31:16];
  assign imm_lo = imm[15:0];

  always_comb begin
    word         = 32'd0;
    needs_second = 1'b0;
    err          = 1'b0;
    case (op)
      ENC_ADD:     word = r_word(rs, rt, rd, FN_ADD);
      ENC_SUB:     word = r_word(rs, rt, rd, FN_SUB);
      ENC_AND:     word = r_word(rs, rt, rd, FN_AND);
      ENC_OR:      word = r_word(rs, rt, rd, FN_OR);
      ENC_SLT:     word = r_word(rs, rt, rd, FN_SLT);
      ENC_JR:      word = r_word(rs, 5'd0, 5'd0, FN_JR);
      ENC_SYSCALL: word = r_word(5'd0, 5'd0, 5'd0, FN_SYSCALL);
      ENC_ADDI:    word = i_word(OP_ADDI, rs, rt, imm_lo);
      ENC_ADDIU:   word = i_word(OP_ADDIU, rs, rt, imm_lo);
      ENC_SLTIU:   word = i_word(OP_SLTIU, rs, rt, imm_lo);
      ENC_ORI:     word = i_word(OP_ORI, rs, rt, imm_lo);
      ENC_LUI:     word = i_word(OP_LUI, 5'd0, rt, imm_lo);
      ENC_LW:      word = i_word(OP_LW, rs, rt, imm_lo);
      ENC_SW:      word = i_word(OP_SW, rs, rt, imm_lo);
      ENC_BEQ:     word = i_word(OP_BEQ, rs, rt, imm_lo);
      ENC_BNE:     word = i_word(OP_BNE, rs, rt, imm_lo);
      ENC_J:       word = j_word(OP_J, imm[27:2]);
      ENC_JAL:     word = j_word(OP_JAL, imm[27:2]);
      ENC_NOP:     word = 32'd0;
      ENC_LI: begin
        // Second half always ORs the low half into the register the LUI just set.
        if (li_phase) begin
          word = i_word(OP_ORI, rt, rt, imm_lo);
        end else if (imm_hi == 16'd0) begin
          word = i_word(OP_ORI, 5'd0, rt, imm_lo);
        end else begin
          word         = i_word(OP_LUI, 5'd0, rt, imm_hi);
          needs_second = (imm_lo != 16'd0);
        end
      end
      default:     err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams symbolic MIPS requests into addressed 32-bit machine words, with a
// one-word registered output stage and LI expansion into LUI/ORI.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
);

  state_t      state_reg, state_next;
  logic        out_valid_reg;
  logic        out_err_reg;
  logic [31:0] out_instr_reg;
  logic [31:0] out_addr_reg;
  logic [4:0]  hold_rt_reg;
  logic [31:0] hold_imm_reg;

  logic        in_li2;
  logic        handshake;
  logic        accept;
  logic        load_word;
  logic [4:0]  fmt_op;
  logic [4:0]  fmt_rs;
  logic [4:0]  fmt_rt;
  logic [4:0]  fmt_rd;
  logic [31:0] fmt_imm;
  logic [31:0] fmt_word;
  logic        fmt_needs_second;
  logic        fmt_err;

  assign in_li2    = (state_reg == ST_LI2);
  assign handshake = out_valid_reg & out_ready;
  assign accept    = req_valid & req_ready;

  // While finishing an LI, the formatter sees the held request instead of the live one.
  assign fmt_op  = in_li2 ? ENC_LI : req_op;
  assign fmt_rs  = in_li2 ? 5'd0 : req_rs;
  assign fmt_rt  = in_li2 ? hold_rt_reg : req_rt;
  assign fmt_rd  = in_li2 ? 5'd0 : req_rd;
  assign fmt_imm = in_li2 ? hold_imm_reg : req_imm;

  assign load_word = (accept & ~fmt_err) | (in_li2 & handshake);

  instr_encoder_fmt u_fmt (
    .op           (fmt_op),
    .rs           (fmt_rs),
    .rt           (fmt_rt),
    .rd           (fmt_rd),
    .imm          (fmt_imm),
    .li_phase     (in_li2),
    .word         (fmt_word),
    .needs_second (fmt_needs_second),
    .err          (fmt_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept && !fmt_err && fmt_needs_second) state_next = ST_LI2;
      ST_LI2:  if (handshake) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    case (state_reg)
      ST_IDLE: req_ready = ~out_valid_reg | out_ready;
      default: req_ready = 1'b0;
    endcase
  end

  // The address register always names the presented word (or the next one when empty).
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_err_reg   <= 1'b0;
      out_instr_reg <= 32'd0;
      out_addr_reg  <= BASE_ADDR;
      hold_rt_reg   <= 5'd0;
      hold_imm_reg  <= 32'd0;
    end else begin
      out_err_reg <= accept & fmt_err;
      if (handshake) begin
        out_addr_reg <= out_addr_reg + 32'd4;
      end
      if (load_word) begin
        out_valid_reg <= 1'b1;
        out_instr_reg <= fmt_word;
      end else if (handshake) begin
        out_valid_reg <= 1'b0;
      end
      if (accept) begin
        hold_rt_reg  <= req_rt;
        hold_imm_reg <= req_imm;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_addr  = out_addr_reg;
  assign out_err   = out_err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the word stream.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  logic        exp_err;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs    (req_rs),
    .req_rt    (req_rt),
    .req_rd    (req_rd),
    .req_imm   (req_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference encoder: field placement by plain shifts from the MIPS format tables.
  function automatic logic [31:0] rfmt(input int rs, input int rt, input int rd, input int fn);
    return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
  endfunction

  function automatic logic [31:0] ifmt(input int opc, input int rs, input int rt, input logic [31:0] v);
    return (32'(opc) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (v & 32'hFFFF);
  endfunction

  task automatic ref_enc(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] imm,
                         output int n, output logic [31:0] w0, output logic [31:0] w1,
                         output logic err);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = imm >> 16;
    lo = imm & 32'hFFFF;
    n = 1; w0 = 32'd0; w1 = 32'd0; err = 1'b0;
    case (int'(op))
      0:  w0 = rfmt(rs, rt, rd, 'h20);
      1:  w0 = rfmt(rs, rt, rd, 'h22);
      2:  w0 = rfmt(rs, rt, rd, 'h24);
      3:  w0 = rfmt(rs, rt, rd, 'h25);
      4:  w0 = rfmt(rs, rt, rd, 'h2A);
      5:  w0 = rfmt(rs, 0, 0, 'h08);
      6:  w0 = 32'h0000_000C;
      7:  w0 = ifmt('h08, rs, rt, imm);
      8:  w0 = ifmt('h09, rs, rt, imm);
      9:  w0 = ifmt('h0B, rs, rt, imm);
      10: w0 = ifmt('h0D, rs, rt, imm);
      11: w0 = ifmt('h0F, 0, rt, imm);
      12: w0 = ifmt('h23, rs, rt, imm);
      13: w0 = ifmt('h2B, rs, rt, imm);
      14: w0 = ifmt('h04, rs, rt, imm);
      15: w0 = ifmt('h05, rs, rt, imm);
      16: w0 = (32'h02 << 26) | ((imm >> 2) & 32'h03FF_FFFF);
      17: w0 = (32'h03 << 26) | ((imm >> 2) & 32'h03FF_FFFF);
      18: begin
        if (hi == 0) begin
          w0 = ifmt('h0D, 0, rt, lo);
        end else if (lo == 0) begin
          w0 = ifmt('h0F, 0, rt, hi);
        end else begin
          n = 2;
          w0 = ifmt('h0F, 0, rt, hi);
          w1 = ifmt('h0D, rt, rt, lo);
        end
      end
      19: w0 = 32'd0;
      default: begin
        n = 0;
        err = 1'b1;
      end
    endcase
  endtask

  // One clock: compare against the model mid-cycle, then advance the model.
  task automatic step();
    logic        exp_ready;
    logic        hs;
    logic        acc;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        e;
    @(negedge clk);
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) check("out_instr", out_instr, exp_q[0]);
    check("out_addr", out_addr, exp_addr);
    check("out_err", {31'd0, out_err}, {31'd0, exp_err});
    check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    hs  = (exp_q.size() > 0) && out_ready;
    acc = req_valid && exp_ready;
    if (hs) $display("out  instr=%h addr=%h", exp_q[0], exp_addr);
    exp_err = 1'b0;
    if (hs) begin
      void'(exp_q.pop_front());
      exp_addr = exp_addr + 32'd4;
    end
    if (acc) begin
      ref_enc(req_op, req_rs, req_rt, req_rd, req_imm, n, w0, w1, e);
      $display("req  op=%0d rs=%0d rt=%0d rd=%0d imm=%h words=%0d err=%0b",
               req_op, req_rs, req_rt, req_rd, req_imm, n, e);
      exp_err = e;
      if (n >= 1) exp_q.push_back(w0);
      if (n == 2) exp_q.push_back(w1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_addr = BASE;
    exp_err  = 1'b0;
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm);
    req_valid = 1'b1;
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
    req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;

    // Reset state
    do_reset();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_addr", out_addr, BASE);
    check("rst_err", {31'd0, out_err}, 32'd0);

    // ADD after reset, one cycle latency
    drive(ENC_ADD, 5'd1, 5'd2, 5'd3, 32'd0);
    step();
    req_valid = 1'b0;
    check("add_instr", out_instr, 32'h0022_1820);
    check("add_addr", out_addr, 32'h0040_0000);
    step();

    // ADDI then SYSCALL back to back
    do_reset();
    drive(ENC_ADDI, 5'd0, 5'd8, 5'd0, 32'd5);
    step();
    check("addi_instr", out_instr, 32'h2008_0005);
    check("addi_addr", out_addr, 32'h0040_0000);
    drive(ENC_SYSCALL, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    req_valid = 1'b0;
    check("sys_instr", out_instr, 32'h0000_000C);
    check("sys_addr", out_addr, 32'h0040_0004);
    step();

    // LI with both halves
    do_reset();
    drive(ENC_LI, 5'd0, 5'd4, 5'd0, 32'h1234_5678);
    step();
    drive(ENC_ADD, 5'd1, 5'd1, 5'd1, 32'd0);
    check("li1_instr", out_instr, 32'h3C04_1234);
    check("li1_ready", {31'd0, req_ready}, 32'd0);
    step();
    check("li2_instr", out_instr, 32'h3484_5678);
    check("li2_addr", out_addr, 32'h0040_0004);
    req_valid = 1'b0;
    repeat (2) step();

    // LI with zero high half
    do_reset();
    drive(ENC_LI, 5'd0, 5'd4, 5'd0, 32'h0000_0010);
    step();
    req_valid = 1'b0;
    check("lis_instr", out_instr, 32'h3404_0010);
    repeat (2) step();

    // J
    do_reset();
    drive(ENC_J, 5'd0, 5'd0, 5'd0, 32'h0040_0018);
    step();
    req_valid = 1'b0;
    check("j_instr", out_instr, 32'h0810_0006);
    step();

    // Backpressure hold
    do_reset();
    out_ready = 1'b0;
    drive(ENC_ADD, 5'd1, 5'd2, 5'd3, 32'd0);
    step();
    drive(ENC_SUB, 5'd1, 5'd2, 5'd3, 32'd0);
    repeat (3) begin
      step();
      check("hold_instr", out_instr, 32'h0022_1820);
      check("hold_addr", out_addr, BASE);
    end
    out_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check("sub_instr", out_instr, 32'h0022_1822);
    check("sub_addr", out_addr, 32'h0040_0004);
    step();

    // Unsupported op
    do_reset();
    drive(5'd31, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    req_valid = 1'b0;
    check("err_pulse", {31'd0, out_err}, 32'd1);
    check("err_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("err_clear", {31'd0, out_err}, 32'd0);
    drive(ENC_ADD, 5'd1, 5'd2, 5'd3, 32'd0);
    step();
    req_valid = 1'b0;
    check("post_err_addr", out_addr, BASE);
    step();

    // Reset between LI halves
    do_reset();
    out_ready = 1'b0;
    drive(ENC_LI, 5'd0, 5'd4, 5'd0, 32'h1234_5678);
    step();
    req_valid = 1'b0;
    step();
    do_reset();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_addr", out_addr, BASE);
    out_ready = 1'b1;
    repeat (3) step();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
      req_rs    = 5'($urandom);
      req_rt    = 5'($urandom);
      req_rd    = 5'($urandom);
      req_imm   = $urandom;
      case ($urandom_range(0, 3))
        0: req_imm[31:16] = 16'd0;
        1: req_imm[15:0]  = 16'd0;
        default: ;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
